fetch_ctrl: RTL and testbench

//  Sequences instruction fetch for the IF stage: owns the fetch PC and issues batch-aligned

---
 rtl/fetch_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for the IF stage.
// Owns the fetch PC and issues batch-aligned I$ requests. Counts accepted but
// unanswered requests and keeps a small in-order tag FIFO so each response can
// be paired with its address and first-valid slot. After a redirect, every
// response still owed by the I$ is squashed. Fetch is throttled by credits
// from the instruction buffer. Each delivered batch is presented for exactly
// one cycle with its PC and a valid-slot mask.
module fetch_ctrl #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] INIT_PC    = '0,
  parameter int unsigned       BATCH      = 2,
  parameter int unsigned       MAX_OUTST  = 2,
  parameter int unsigned       IBUF_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [ADDR_W-1:0]     redirect_pc,
  output logic                  ic_req_valid,
  input  logic                  ic_req_ready,
  output logic [ADDR_W-1:0]     ic_req_addr,
  input  logic                  ic_resp_valid,
  input  logic [32*BATCH-1:0]   ic_resp_data,
  output logic                  out_valid,
  output logic [ADDR_W-1:0]     out_pc,
  output logic [32*BATCH-1:0]   out_inst,
  output logic [BATCH-1:0]      out_mask,
  input  logic                  ibuf_pop
);

  localparam int unsigned STEP   = BATCH * 4;
  localparam int unsigned SLOT_W = (BATCH > 1) ? $clog2(BATCH) : 1;
  localparam int unsigned OUT_W  = $clog2(MAX_OUTST + 1);
  localparam int unsigned CRD_W  = $clog2(IBUF_DEPTH + 1);
  localparam int unsigned PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  localparam logic [OUT_W-1:0]  OUTST_MAX = OUT_W'(MAX_OUTST);
  localparam logic [CRD_W-1:0]  CRD_MAX   = CRD_W'(IBUF_DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MSK = ~ADDR_W'(STEP - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(MAX_OUTST - 1);

  typedef enum logic [1:0] {
    BOOT0 = 2'd0,
    BOOT1 = 2'd1,
    RUN   = 2'd2
  } state_e;

  // One entry per accepted request: where the batch lives and which slot the
  // program actually entered at.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [SLOT_W-1:0] slot;
  } tag_t;

  state_e             state_q, state_d;
  logic               run;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [OUT_W-1:0]   outst_q, outst_d;
  logic [OUT_W-1:0]   drop_q, drop_d;
  logic [CRD_W-1:0]   credits_q, credits_d;

  tag_t               tag_mem [MAX_OUTST];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  tag_t               rd_tag;
  logic [SLOT_W-1:0]  wr_slot;

  logic               req_fire;
  logic               resp_take;
  logic               resp_drop;
  logic               resp_keep;
  logic               dlv_valid_q;
  logic               dlv_kill;
  logic [BATCH-1:0]   resp_mask;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // FSM state register: two settle cycles after reset, then fetch forever.
  // NOTE: sequential state is written with <= so every flop samples the
  // values from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT0;
    else        state_q <= state_d;
  end

  // FSM next state: BOOT0 -> BOOT1 -> RUN, RUN is terminal.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT0:   state_d = BOOT1;
      BOOT1:   state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT0;
    endcase
  end

  // FSM outputs: fetching is only allowed once the memories have settled.
  always_comb begin
    run = (state_q == RUN);
  end

  assign ic_req_addr  = pc_q & ALIGN_MSK;
  assign ic_req_valid = run && (outst_q < OUTST_MAX) && (credits_q != '0) && !redirect_valid;
  assign req_fire     = ic_req_valid && ic_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_take = ic_resp_valid && (outst_q != '0);
  assign resp_drop = resp_take && ((drop_q != '0) || redirect_valid);
  assign resp_keep = resp_take && !resp_drop;

  // A batch captured last cycle is already stale if a redirect shows up now;
  // its buffer slot was never used, so the credit comes back.
  assign dlv_kill  = dlv_valid_q && redirect_valid;
  assign out_valid = dlv_valid_q && !redirect_valid;

  assign rd_tag  = tag_mem[rd_ptr_q];
  assign wr_slot = (BATCH > 1) ? SLOT_W'(pc_q >> 2) : '0;

  // Slot mask: slots before the entry offset belong to the previous path.
  always_comb begin
    resp_mask = '0;
    for (int i = 0; i < BATCH; i++) begin
      resp_mask[i] = (i >= int'(rd_tag.slot));
    end
  end

  // Next PC, outstanding/drop counters and credits.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)  pc_d = redirect_pc;
    else if (req_fire)   pc_d = ic_req_addr + ADDR_W'(STEP);

    outst_d = outst_q;
    if (req_fire && !resp_take)      outst_d = outst_q + OUT_W'(1);
    else if (!req_fire && resp_take) outst_d = outst_q - OUT_W'(1);

    drop_d = drop_q;
    if (resp_take && (drop_q != '0)) drop_d = drop_q - OUT_W'(1);
    // Everything still owed by the I$ after this cycle belongs to the old
    // path; drop never exceeds outst, so this is drop plus the live count.
    if (redirect_valid)              drop_d = outst_d;

    credits_d = credits_q + CRD_W'(ibuf_pop) + CRD_W'(resp_drop)
              + CRD_W'(dlv_kill) - CRD_W'(req_fire);
  end

  // Control registers and tag FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= INIT_PC;
      outst_q   <= '0;
      drop_q    <= '0;
      credits_q <= CRD_MAX;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      credits_q <= credits_d;
      if (req_fire)  wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (resp_take) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Tag FIFO storage, written on every accepted request.
  // NOTE: the storage array has no reset; the pointers and outst define which
  // entries are live, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[wr_ptr_q] <= '{addr: ic_req_addr, slot: wr_slot};
  end

  // Delivery register: one-cycle pulse per kept response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dlv_valid_q <= 1'b0;
      out_pc      <= '0;
      out_inst    <= '0;
      out_mask    <= '0;
    end else begin
      dlv_valid_q <= resp_keep;
      if (resp_keep) begin
        out_pc   <= rd_tag.addr;
        out_inst <= ic_resp_data;
        out_mask <= resp_mask;
      end
    end
  end

  a_credits_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    credits_q <= CRD_MAX);

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
    !(ic_resp_valid && (outst_q == '0)));

  a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (ic_req_valid && !ic_req_ready) |=> (ic_req_valid || redirect_valid));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a 1-cycle-latency I$ model answers every
// accepted request in order; each test task checks requests and deliveries
// against hand-computed addresses, masks and cycle numbers.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ic_req_valid;
  logic        ic_req_ready;
  logic [31:0] ic_req_addr;
  logic        ic_resp_valid;
  logic [63:0] ic_resp_data;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [63:0] out_inst;
  logic [1:0]  out_mask;
  logic        ibuf_pop;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  mask;
    logic [63:0] inst;
  } dlv_t;

  logic [31:0] pend_q[$];
  logic [31:0] req_log[$];
  dlv_t        out_log[$];
  bit          resp_en;
  bit          auto_pop;
  int          cyc;
  int          first_req_cyc;
  int          first_out_cyc;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  fetch_ctrl #(
    .ADDR_W(32), .INIT_PC(32'h0000_0000), .BATCH(2), .MAX_OUTST(2), .IBUF_DEPTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_mask(out_mask),
    .ibuf_pop(ibuf_pop)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // I$ contents: slot 0 at bits [31:0], slot 1 at bits [63:32].
  function automatic logic [63:0] mk_data(input logic [31:0] a);
    return {(a + 32'd4) ^ 32'hC0DE_0000, a ^ 32'hC0DE_0000};
  endfunction

  function automatic logic [31:0] req_at(input int i);
    return (i < req_log.size()) ? req_log[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic dlv_t dlv_at(input int i);
    dlv_t d;
    d = 'x;
    if (i < out_log.size()) d = out_log[i];
    return d;
  endfunction

  // One clock cycle: sample outputs with this cycle's inputs, then let the
  // I$ model drive its response for the next cycle.
  task automatic step();
    logic        pop_nxt;
    logic [31:0] a;
    #1;
    if (ic_req_valid && first_req_cyc < 0) first_req_cyc = cyc;
    if (ic_req_valid && ic_req_ready) begin
      req_log.push_back(ic_req_addr);
      pend_q.push_back(ic_req_addr);
    end
    if (out_valid) begin
      out_log.push_back('{pc: out_pc, mask: out_mask, inst: out_inst});
      if (first_out_cyc < 0) first_out_cyc = cyc;
    end
    pop_nxt = auto_pop && out_valid;
    @(posedge clk);
    #1;
    cyc++;
    ic_resp_valid = 1'b0;
    ic_resp_data  = '0;
    if (resp_en && pend_q.size() != 0) begin
      a = pend_q.pop_front();
      ic_resp_valid = 1'b1;
      ic_resp_data  = mk_data(a);
    end
    if (auto_pop) ibuf_pop = pop_nxt;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset released one unit after an edge; the following cycle is cycle 1.
  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ic_req_ready   = 1'b1;
    ic_resp_valid  = 1'b0;
    ic_resp_data   = '0;
    ibuf_pop       = 1'b0;
    resp_en        = 1'b1;
    auto_pop       = 1'b0;
    first_req_cyc  = -1;
    first_out_cyc  = -1;
    pend_q.delete();
    req_log.delete();
    out_log.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    ic_resp_valid  = 1'b0;
    ibuf_pop       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (ic_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", ic_req_valid); else pass_cnt++;
    total_cnt++; if (ic_req_addr !== 32'h0) $display("FAIL reset_req_addr: got %h want 0", ic_req_addr); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_pc !== 32'h0) $display("FAIL reset_out_pc: got %h want 0", out_pc); else pass_cnt++;
    total_cnt++; if (out_mask !== 2'b00) $display("FAIL reset_out_mask: got %b want 00", out_mask); else pass_cnt++;
    total_cnt++; if (out_inst !== 64'h0) $display("FAIL reset_out_inst: got %h want 0", out_inst); else pass_cnt++;
  endtask

  task automatic test_basic_fetch();
    do_reset();
    auto_pop = 1'b1;
    steps(10);
    total_cnt++; if (first_req_cyc !== 3) $display("FAIL basic_first_req_cycle: got %0d want 3", first_req_cyc); else pass_cnt++;
    total_cnt++; if (first_out_cyc !== 5) $display("FAIL basic_first_out_cycle: got %0d want 5", first_out_cyc); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp_a;
      dlv_t        d;
      exp_a = 32'(i * 8);
      d     = dlv_at(i);
      total_cnt++; if (req_at(i) !== exp_a) $display("FAIL basic_req_addr[%0d]: got %h want %h", i, req_at(i), exp_a); else pass_cnt++;
      total_cnt++; if (d.pc !== exp_a) $display("FAIL basic_out_pc[%0d]: got %h want %h", i, d.pc, exp_a); else pass_cnt++;
      total_cnt++; if (d.mask !== 2'b11) $display("FAIL basic_out_mask[%0d]: got %b want 11", i, d.mask); else pass_cnt++;
      total_cnt++; if (d.inst !== mk_data(exp_a)) $display("FAIL basic_out_inst[%0d]: got %h want %h", i, d.inst, mk_data(exp_a)); else pass_cnt++;
    end
  endtask

  task automatic test_redirect_drop();
    dlv_t d;
    do_reset();
    resp_en  = 1'b0;
    auto_pop = 1'b1;
    steps(4);
    #1;
    total_cnt++; if (ic_req_valid !== 1'b0) $display("FAIL drop_outst_limit: got req_valid %b want 0", ic_req_valid); else pass_cnt++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0104;
    step();
    redirect_valid = 1'b0;
    resp_en        = 1'b1;
    steps(10);
    total_cnt++; if (req_at(2) !== 32'h100) $display("FAIL drop_req_after_redirect: got %h want 00000100", req_at(2)); else pass_cnt++;
    total_cnt++; if (req_at(3) !== 32'h108) $display("FAIL drop_req_next: got %h want 00000108", req_at(3)); else pass_cnt++;
    d = dlv_at(0);
    total_cnt++; if (d.pc !== 32'h100) $display("FAIL drop_first_out_pc: got %h want 00000100", d.pc); else pass_cnt++;
    total_cnt++; if (d.mask !== 2'b10) $display("FAIL drop_first_out_mask: got %b want 10", d.mask); else pass_cnt++;
    total_cnt++; if (d.inst !== mk_data(32'h100)) $display("FAIL drop_first_out_inst: got %h want %h", d.inst, mk_data(32'h100)); else pass_cnt++;
    d = dlv_at(1);
    total_cnt++; if (d.pc !== 32'h108) $display("FAIL drop_second_out_pc: got %h want 00000108", d.pc); else pass_cnt++;
    total_cnt++; if (d.mask !== 2'b11) $display("FAIL drop_second_out_mask: got %b want 11", d.mask); else pass_cnt++;
  endtask

  task automatic test_credits();
    do_reset();
    steps(20);
    total_cnt++; if (req_log.size() !== 8) $display("FAIL credit_req_count: got %0d want 8", req_log.size()); else pass_cnt++;
    total_cnt++; if (out_log.size() !== 8) $display("FAIL credit_out_count: got %0d want 8", out_log.size()); else pass_cnt++;
    total_cnt++; if (req_at(7) !== 32'h38) $display("FAIL credit_last_addr: got %h want 00000038", req_at(7)); else pass_cnt++;
    total_cnt++; if (ic_req_valid !== 1'b0) $display("FAIL credit_stall: got req_valid %b want 0", ic_req_valid); else pass_cnt++;
    ibuf_pop = 1'b1;
    step();
    ibuf_pop = 1'b0;
    steps(4);
    total_cnt++; if (req_log.size() !== 9) $display("FAIL credit_pop_req_count: got %0d want 9", req_log.size()); else pass_cnt++;
    total_cnt++; if (req_at(8) !== 32'h40) $display("FAIL credit_pop_addr: got %h want 00000040", req_at(8)); else pass_cnt++;
    total_cnt++; if (ic_req_valid !== 1'b0) $display("FAIL credit_restall: got req_valid %b want 0", ic_req_valid); else pass_cnt++;
  endtask

  task automatic test_redirect_same_resp();
    do_reset();
    steps(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    steps(25);
    total_cnt++; if (req_log.size() !== 9) $display("FAIL same_req_count: got %0d want 9", req_log.size()); else pass_cnt++;
    total_cnt++; if (req_at(1) !== 32'h200) $display("FAIL same_first_new_addr: got %h want 00000200", req_at(1)); else pass_cnt++;
    total_cnt++; if (req_at(8) !== 32'h238) $display("FAIL same_last_addr: got %h want 00000238", req_at(8)); else pass_cnt++;
    total_cnt++; if (out_log.size() !== 8) $display("FAIL same_out_count: got %0d want 8", out_log.size()); else pass_cnt++;
    total_cnt++; if (dlv_at(0).pc !== 32'h200) $display("FAIL same_first_out_pc: got %h want 00000200", dlv_at(0).pc); else pass_cnt++;
  endtask

  task automatic test_suppress();
    do_reset();
    steps(4);
    #1;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL supp_pre_valid: got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_pc !== 32'h0) $display("FAIL supp_pre_pc: got %h want 0", out_pc); else pass_cnt++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL supp_gated: got out_valid %b want 0", out_valid); else pass_cnt++;
    step();
    redirect_valid = 1'b0;
    steps(6);
    total_cnt++; if (req_at(2) !== 32'h300) $display("FAIL supp_new_req: got %h want 00000300", req_at(2)); else pass_cnt++;
    total_cnt++; if (dlv_at(0).pc !== 32'h300) $display("FAIL supp_first_out_pc: got %h want 00000300", dlv_at(0).pc); else pass_cnt++;
  endtask

  task automatic test_stall_wrap();
    dlv_t d;
    do_reset();
    auto_pop       = 1'b1;
    ic_req_ready   = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      total_cnt++; if ({ic_req_valid, ic_req_addr} !== {1'b1, 32'hFFFF_FFF8}) $display("FAIL stall_hold[%0d]: got valid %b addr %h want 1 fffffff8", i, ic_req_valid, ic_req_addr); else pass_cnt++;
      step();
    end
    ic_req_ready = 1'b1;
    steps(5);
    total_cnt++; if (first_req_cyc !== 3) $display("FAIL wrap_first_req_cycle: got %0d want 3", first_req_cyc); else pass_cnt++;
    total_cnt++; if (req_at(0) !== 32'hFFFF_FFF8) $display("FAIL wrap_req0: got %h want fffffff8", req_at(0)); else pass_cnt++;
    total_cnt++; if (req_at(1) !== 32'h0) $display("FAIL wrap_req1: got %h want 00000000", req_at(1)); else pass_cnt++;
    d = dlv_at(0);
    total_cnt++; if (d.pc !== 32'hFFFF_FFF8) $display("FAIL wrap_out_pc: got %h want fffffff8", d.pc); else pass_cnt++;
    total_cnt++; if (d.mask !== 2'b11) $display("FAIL wrap_out_mask: got %b want 11", d.mask); else pass_cnt++;
    total_cnt++; if (d.inst !== mk_data(32'hFFFF_FFF8)) $display("FAIL wrap_out_inst: got %h want %h", d.inst, mk_data(32'hFFFF_FFF8)); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    auto_pop = 1'b1;
    steps(6);
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (ic_req_valid !== 1'b0) $display("FAIL midrst_req_valid: got %b want 0", ic_req_valid); else pass_cnt++;
    total_cnt++; if (ic_req_addr !== 32'h0) $display("FAIL midrst_req_addr: got %h want 0", ic_req_addr); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", out_valid); else pass_cnt++;
    do_reset();
    steps(6);
    total_cnt++; if (first_req_cyc !== 3) $display("FAIL midrst_first_req_cycle: got %0d want 3", first_req_cyc); else pass_cnt++;
    total_cnt++; if (req_at(0) !== 32'h0) $display("FAIL midrst_req0: got %h want 0", req_at(0)); else pass_cnt++;
    total_cnt++; if (dlv_at(0).pc !== 32'h0) $display("FAIL midrst_out_pc: got %h want 0", dlv_at(0).pc); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_redirect_drop();
    test_credits();
    test_redirect_same_resp();
    test_suppress();
    test_stall_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
